// File: rtl/mem_access_stage.sv
// MEM-stage data-memory access unit: req/ack transaction, store lane steering, load align/extend.
// Optional feature macro: DMEM_TIMEOUT_EN (abandons an access after TIMEOUT_CYCLES WAIT cycles).
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] EX_MEM__ALU_Main,
    input  logic [63:0] EX_MEM__Write_Data,
    input  logic        EX_MEM__MemRead,
    input  logic        EX_MEM__MemWrite,
    input  logic [2:0]  EX_MEM__Funct3,
    input  logic        dmem_ack,
    input  logic [63:0] dmem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    output logic [7:0]  dmem_wstrb,
    output logic [63:0] MEM__Read_Data,
    output logic        mem_stall,
    output logic        mem_misaligned,
    output logic        mem_fault
);
    localparam int unsigned XLEN  = 64;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

    state_t          state;
    logic [2:0]      offset;
    logic [2:0]      offset_q;
    logic [2:0]      funct3_q;
    logic            access;
    logic            legal;
    logic            aligned;
    logic            launch;
    logic            illegal;
    logic            misaligned;
    logic            timeout;
    logic [7:0]      size_mask;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_value;

    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    assign offset     = EX_MEM__ALU_Main[2:0];
    assign access     = EX_MEM__MemRead ^ EX_MEM__MemWrite;
    // 111 is never legal; unsigned variants exist only for loads
    assign legal      = (EX_MEM__Funct3 != 3'b111) && !(EX_MEM__MemWrite && EX_MEM__Funct3[2]);
    assign launch     = (state == IDLE) && access && aligned && legal;
    assign illegal    = (EX_MEM__MemRead && EX_MEM__MemWrite) || (access && !legal);
    assign misaligned = access && legal && !aligned;
    // Held low during reset so a pending instruction cannot freeze the pipe
    assign mem_stall  = reset && (launch || (state == WAIT));

    always_comb begin
        aligned   = 1'b1;
        size_mask = 8'h01;
        case (EX_MEM__Funct3[1:0])
            2'b00: begin aligned = 1'b1;              size_mask = 8'h01; end
            2'b01: begin aligned = (offset[0] == 1'b0);     size_mask = 8'h03; end
            2'b10: begin aligned = (offset[1:0] == 2'b00);  size_mask = 8'h0F; end
            default: begin aligned = (offset == 3'b000);    size_mask = 8'hFF; end
        endcase
    end

    // Load alignment and extension, using the size/sign captured at launch
    always_comb begin
        shifted    = dmem_rdata >> {offset_q, 3'b000};
        load_value = shifted;
        case (funct3_q)
            3'b000:  load_value = {{56{shifted[7]}},  shifted[7:0]};
            3'b001:  load_value = {{48{shifted[15]}}, shifted[15:0]};
            3'b010:  load_value = {{32{shifted[31]}}, shifted[31:0]};
            3'b100:  load_value = {56'd0, shifted[7:0]};
            3'b101:  load_value = {48'd0, shifted[15:0]};
            3'b110:  load_value = {32'd0, shifted[31:0]};
            default: load_value = shifted;
        endcase
    end

`ifdef DMEM_TIMEOUT_EN
    logic [CNT_W-1:0] wait_cnt;

    assign timeout = (CNT_W'(wait_cnt + CNT_W'(1)) == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= CNT_W'(wait_cnt + CNT_W'(1));
        end else begin
            wait_cnt <= '0;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= '0;
            dmem_wdata     <= '0;
            dmem_wstrb     <= '0;
            MEM__Read_Data <= '0;
            mem_misaligned <= 1'b0;
            mem_fault      <= 1'b0;
            offset_q       <= '0;
            funct3_q       <= '0;
        end else begin
            mem_misaligned <= 1'b0;
            mem_fault      <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= EX_MEM__MemWrite;
                        dmem_addr  <= {EX_MEM__ALU_Main[63:3], 3'b000};
                        dmem_wdata <= EX_MEM__Write_Data << {offset, 3'b000};
                        dmem_wstrb <= size_mask << offset;
                        offset_q   <= offset;
                        funct3_q   <= EX_MEM__Funct3;
                        state      <= WAIT;
                    end else if (illegal) begin
                        mem_fault      <= 1'b1;
                        MEM__Read_Data <= '0;
                    end else if (misaligned) begin
                        mem_misaligned <= 1'b1;
                        MEM__Read_Data <= '0;
                    end
                end
                WAIT: begin
                    // A response in the timeout cycle still completes the access
                    if (dmem_ack) begin
                        dmem_req       <= 1'b0;
                        MEM__Read_Data <= dmem_we ? '0 : load_value;
                        state          <= DONE;
                    end else if (timeout) begin
                        dmem_req       <= 1'b0;
                        MEM__Read_Data <= '0;
                        mem_fault      <= 1'b1;
                        state          <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: vector table with a read-data scoreboard plus reset/timeout sequences.
module tb_mem_access_stage;
    logic        clk;
    logic        reset;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic        ack;
    logic [63:0] rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic [7:0]  dmem_wstrb;
    logic [63:0] read_data;
    logic        mem_stall;
    logic        mem_misaligned;
    logic        mem_fault;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          n;
        logic        launch;
        logic        mis;
        logic        fault;
        logic [7:0]  wstrb;
        logic [63:0] exp_wdata;
        logic [63:0] exp_read;
    } vec_t;

    vec_t        vecs[16];
    logic [63:0] exp_q[$];

    mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk                (clk),
        .reset              (reset),
        .EX_MEM__ALU_Main   (addr),
        .EX_MEM__Write_Data (wdata),
        .EX_MEM__MemRead    (rd),
        .EX_MEM__MemWrite   (wr),
        .EX_MEM__Funct3     (f3),
        .dmem_ack           (ack),
        .dmem_rdata         (rdata),
        .dmem_req           (dmem_req),
        .dmem_we            (dmem_we),
        .dmem_addr          (dmem_addr),
        .dmem_wdata         (dmem_wdata),
        .dmem_wstrb         (dmem_wstrb),
        .MEM__Read_Data     (read_data),
        .mem_stall          (mem_stall),
        .mem_misaligned     (mem_misaligned),
        .mem_fault          (mem_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic w, input logic [2:0] f, input logic [63:0] a,
                                input logic [63:0] wd, input logic [63:0] rdv, input int n,
                                input logic l, input logic m, input logic flt, input logic [7:0] s,
                                input logic [63:0] ew, input logic [63:0] er);
        vec_t v;
        v.rd = r; v.wr = w; v.f3 = f; v.addr = a; v.wdata = wd; v.rdata = rdv; v.n = n;
        v.launch = l; v.mis = m; v.fault = flt; v.wstrb = s; v.exp_wdata = ew; v.exp_read = er;
        return v;
    endfunction

    task automatic idle_inputs();
        rd = 1'b0; wr = 1'b0; f3 = 3'b000; addr = '0; wdata = '0; ack = 1'b0; rdata = '0;
    endtask

    // Drive one instruction from an IDLE cycle and follow it to completion
    task automatic run_vec(input int idx, input vec_t v);
        int          req_cnt;
        int          stall_cnt;
        logic [63:0] exp;
        @(negedge clk);
        rd = v.rd; wr = v.wr; f3 = v.f3; addr = v.addr; wdata = v.wdata; ack = 1'b0;
        exp_q.push_back(v.exp_read);
        #1;
        check($sformatf("v%0d stall_issue", idx), 64'(mem_stall), 64'(v.launch));
        if (v.launch) begin
            stall_cnt = 1;
            req_cnt   = 0;
            for (int c = 1; c <= v.n; c++) begin
                @(negedge clk);
                if (c == v.n) begin
                    ack = 1'b1; rdata = v.rdata;
                end
                #1;
                if (dmem_req)  req_cnt++;
                if (mem_stall) stall_cnt++;
                if (c == 1) begin
                    check($sformatf("v%0d dmem_addr", idx), dmem_addr, {v.addr[63:3], 3'b000});
                    check($sformatf("v%0d dmem_we", idx), 64'(dmem_we), 64'(v.wr));
                    check($sformatf("v%0d dmem_wdata", idx), dmem_wdata, v.exp_wdata);
                    check($sformatf("v%0d dmem_wstrb", idx), 64'(dmem_wstrb), 64'(v.wstrb));
                end
            end
            @(negedge clk);
            ack = 1'b0; rdata = '1;
            #1;
            check($sformatf("v%0d req_cycles", idx), 64'(req_cnt), 64'(v.n));
            check($sformatf("v%0d stall_cycles", idx), 64'(stall_cnt), 64'(v.n + 1));
            check($sformatf("v%0d done_req", idx), 64'(dmem_req), 64'(0));
            check($sformatf("v%0d done_stall", idx), 64'(mem_stall), 64'(0));
            check($sformatf("v%0d done_fault", idx), 64'(mem_fault), 64'(0));
            exp = exp_q.pop_front();
            check($sformatf("v%0d read_data", idx), read_data, exp);
            idle_inputs();
            @(negedge clk);
            #1;
            check($sformatf("v%0d no_relaunch", idx), 64'(dmem_req), 64'(0));
        end else begin
            @(negedge clk);
            #1;
            check($sformatf("v%0d misaligned", idx), 64'(mem_misaligned), 64'(v.mis));
            check($sformatf("v%0d fault", idx), 64'(mem_fault), 64'(v.fault));
            check($sformatf("v%0d no_req", idx), 64'(dmem_req), 64'(0));
            exp = exp_q.pop_front();
            check($sformatf("v%0d read_data", idx), read_data, exp);
            idle_inputs();
            @(negedge clk);
            #1;
            check($sformatf("v%0d pulse_end", idx), 64'({mem_misaligned, mem_fault}), 64'(0));
        end
    endtask

    initial begin
        int   req_cnt;
        logic ended;
        vecs[0]  = mk(1, 0, 3'b011, 64'h1000, 0, 64'h1122334455667788, 1, 1, 0, 0, 8'hFF, 0, 64'h1122334455667788);
        vecs[1]  = mk(1, 0, 3'b011, 64'h1004, 0, 0, 0, 0, 1, 0, 8'h00, 0, 0);
        vecs[2]  = mk(1, 0, 3'b000, 64'h1003, 0, 64'h80000000, 1, 1, 0, 0, 8'h08, 0, 64'hFFFFFFFFFFFFFF80);
        vecs[3]  = mk(1, 0, 3'b100, 64'h1003, 0, 64'h80000000, 1, 1, 0, 0, 8'h08, 0, 64'h80);
        vecs[4]  = mk(0, 1, 3'b001, 64'h2006, 64'hABCD, 0, 3, 1, 0, 0, 8'hC0, 64'hABCD000000000000, 0);
        vecs[5]  = mk(1, 0, 3'b001, 64'h300A, 0, 64'h80010000, 2, 1, 0, 0, 8'h0C, 0, 64'hFFFFFFFFFFFF8001);
        vecs[6]  = mk(0, 1, 3'b100, 64'h8000, 64'h11, 0, 0, 0, 0, 1, 8'h00, 0, 0);
        vecs[7]  = mk(1, 0, 3'b110, 64'h4004, 0, 64'hDEADBEEF00000000, 1, 1, 0, 0, 8'hF0, 0, 64'hDEADBEEF);
        vecs[8]  = mk(1, 1, 3'b011, 64'h8008, 0, 0, 0, 0, 0, 1, 8'h00, 0, 0);
        vecs[9]  = mk(1, 0, 3'b010, 64'h4004, 0, 64'hDEADBEEF00000000, 1, 1, 0, 0, 8'hF0, 0, 64'hFFFFFFFFDEADBEEF);
        vecs[10] = mk(1, 0, 3'b111, 64'h8010, 0, 0, 0, 0, 0, 1, 8'h00, 0, 0);
        vecs[11] = mk(1, 0, 3'b101, 64'h100E, 0, 64'hBEEF000000000000, 2, 1, 0, 0, 8'hC0, 0, 64'hBEEF);
        vecs[12] = mk(1, 0, 3'b010, 64'h1002, 0, 0, 0, 0, 1, 0, 8'h00, 0, 0);
        vecs[13] = mk(0, 1, 3'b000, 64'h5005, 64'h1234, 0, 1, 1, 0, 0, 8'h20, 64'h0012340000000000, 0);
        vecs[14] = mk(0, 1, 3'b010, 64'h6004, 64'hCAFEF00D, 0, 1, 1, 0, 0, 8'hF0, 64'hCAFEF00D00000000, 0);
        vecs[15] = mk(0, 1, 3'b011, 64'h7000, 64'h0123456789ABCDEF, 0, 2, 1, 0, 0, 8'hFF,
                      64'h0123456789ABCDEF, 0);

        reset = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        #1;
        check("rst dmem_req", 64'(dmem_req), 0);
        check("rst mem_stall", 64'(mem_stall), 0);
        check("rst dmem_we", 64'(dmem_we), 0);
        check("rst dmem_addr", dmem_addr, 0);
        check("rst dmem_wdata", dmem_wdata, 0);
        check("rst dmem_wstrb", 64'(dmem_wstrb), 0);
        check("rst read_data", read_data, 0);
        check("rst pulses", 64'({mem_misaligned, mem_fault}), 0);
        reset = 1'b1;

        for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

        // Read data holds while no access is in flight
        run_vec(16, vecs[0]);
        repeat (3) @(negedge clk);
        #1;
        check("hold read_data", read_data, 64'h1122334455667788);

        // Reset during WAIT, then a stray late ack
        @(negedge clk);
        rd = 1'b1; f3 = 3'b011; addr = 64'h1000;
        @(negedge clk);
        #1;
        check("pre_rst req", 64'(dmem_req), 1);
        reset = 1'b0;
        #1;
        check("mid_rst req", 64'(dmem_req), 0);
        check("mid_rst stall", 64'(mem_stall), 0);
        check("mid_rst read_data", read_data, 0);
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;
        ack = 1'b1; rdata = 64'hFFFF0000FFFF0000;
        @(negedge clk);
        ack = 1'b0;
        #1;
        check("late_ack req", 64'(dmem_req), 0);
        check("late_ack stall", 64'(mem_stall), 0);
        check("late_ack read_data", read_data, 0);
        run_vec(17, vecs[0]);

`ifdef DMEM_TIMEOUT_EN
        // No ack: request abandoned after 4 WAIT cycles
        @(negedge clk);
        rd = 1'b1; f3 = 3'b011; addr = 64'h9000;
        req_cnt = 0;
        ended   = 1'b0;
        for (int c = 0; c < 20 && !ended; c++) begin
            @(negedge clk);
            #1;
            if (dmem_req) req_cnt++;
            else ended = 1'b1;
        end
        check("timeout bound", 64'(ended), 1);
        check("timeout req_cycles", 64'(req_cnt), 4);
        check("timeout fault", 64'(mem_fault), 1);
        check("timeout stall", 64'(mem_stall), 0);
        check("timeout read_data", read_data, 0);
        idle_inputs();
        @(negedge clk);
        #1;
        check("timeout fault_end", 64'(mem_fault), 0);
        check("timeout idle_req", 64'(dmem_req), 0);
        // Ack in the timeout cycle wins
        run_vec(18, mk(1, 0, 3'b011, 64'hA000, 0, 64'h5555AAAA5555AAAA, 4, 1, 0, 0, 8'hFF, 0,
                       64'h5555AAAA5555AAAA));
`else
        // Without the timeout the request waits as long as needed
        run_vec(18, mk(1, 0, 3'b011, 64'hA000, 0, 64'h5555AAAA5555AAAA, 12, 1, 0, 0, 8'hFF, 0,
                       64'h5555AAAA5555AAAA));
        ended   = 1'b1;
        req_cnt = 0;
        check("long_wait idle_req", 64'(dmem_req), 64'(req_cnt));
        check("long_wait flag", 64'(ended), 64'(!mem_stall));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM-stage data-memory access unit. It sits between the EX_MEM pipeline register and the MEM_WB pipeline register.
- Takes address, store data and control from EX_MEM and runs a req/ack transaction on the data-memory port.
- Aligns and extends load data, then presents it as the Read_Data feeding MEM_WB.
- Asserts mem_stall to the hazard unit while an access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: maximum WAIT cycles without dmem_ack before the access is abandoned. Range 1..255.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset)
- EX_MEM__ALU_Main  input  64  byte address of the access
- EX_MEM__Write_Data  input  64  store data, right-aligned
- EX_MEM__MemRead  input  1  load request
- EX_MEM__MemWrite  input  1  store request
- EX_MEM__Funct3  input  3  size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU, 111 illegal
- dmem_ack  input  1  memory completion, one-cycle pulse
- dmem_rdata  input  64  read doubleword, valid with dmem_ack
- dmem_req  output  1  request, held until ack
- dmem_we  output  1  1 = store
- dmem_addr  output  64  doubleword address, {addr[63:3],3'b000}
- dmem_wdata  output  64  store data shifted to the byte lane
- dmem_wstrb  output  8  byte enables
- MEM__Read_Data  output  64  extended load result, to MEM_WB
- mem_stall  output  1  freeze IF..EX_MEM; combinational
- mem_misaligned  output  1  one-cycle pulse
- mem_fault  output  1  one-cycle pulse (timeout, illegal Funct3, both Read and Write)

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - state = IDLE, timeout counter = 0.
  - All registered outputs = 0, so dmem_req drops at once.
  - A response arriving after reset is ignored.
- access = MemRead ^ MemWrite.
- aligned = offset addr[2:0] is a multiple of the size (B: 1, H: 2, W: 4, D: 8).
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - If access, aligned and Funct3 legal: register dmem_addr, dmem_we, dmem_wdata and dmem_wstrb; set dmem_req = 1; go to WAIT. The first edge launches the request.
  - If access and misaligned: no request; pulse mem_misaligned next cycle; MEM__Read_Data = 0; stay in IDLE.
  - If MemRead and MemWrite are both 1, or Funct3 = 111 with access: no request; pulse mem_fault; stay in IDLE.
  - Store with Funct3 100/101/110 is illegal and handled as above.
- WAIT:
  - dmem_req and all dmem_* outputs are held stable.
  - On dmem_ack: dmem_req = 0; go to DONE.
    - Load: MEM__Read_Data = (dmem_rdata >> 8*offset), truncated to size, then sign-extended (000/001/010) or zero-extended (100/101/110); 011 uses the full 64 bits.
    - Store: MEM__Read_Data = 0.
  - Counter increments each WAIT cycle. When it reaches TIMEOUT_CYCLES with no ack: dmem_req = 0, MEM__Read_Data = 0, pulse mem_fault, go to DONE. An ack arriving in that same cycle wins.
- DONE:
  - Exactly one cycle, stall low, so EX_MEM and MEM_WB both advance.
  - Unconditionally returns to IDLE and does not relaunch the same instruction.
  - Counter is cleared.
- mem_stall = (IDLE & access & aligned & legal) | WAIT.
- Latency: a zero-wait memory (ack in the first WAIT cycle) gives a stall of 2 cycles; each extra ack cycle adds 1.
- Store encoding:
  - dmem_wdata = Write_Data << 8*offset.
  - dmem_wstrb = size mask << offset: B = 0x01, H = 0x03, W = 0x0F, D = 0xFF.
- MEM__Read_Data holds its value when no access is in flight. It is cleared only by a store, misalign, fault or reset.

Optional Feature:
- DMEM_TIMEOUT_EN defined: the timeout counter and the timeout branch of mem_fault are present, as described above.
- Undefined: no counter, and WAIT lasts until dmem_ack indefinitely. mem_fault then covers only the illegal-encoding cases. TIMEOUT_CYCLES is ignored.

Test Plan:
- Load LD, addr 0x1000, ack 1 cycle after req, rdata 0x1122334455667788 -> req high 1 cycle, dmem_addr 0x1000, stall 2 cycles, Read_Data 0x1122334455667788 in DONE.
- Load LB, addr 0x1003, rdata 0x00000000_80000000 (byte 3 = 0x80) -> Read_Data 0xFFFFFFFFFFFFFF80. Same access with LBU -> Read_Data 0x0000000000000080.
- Store SH, addr 0x2006, Write_Data 0xABCD, ack after 3 cycles -> dmem_wstrb 0xC0, dmem_wdata 0xABCD000000000000, dmem_we 1, req held 3 cycles, stall 4 cycles.
- Load LW, addr 0x1002 -> no dmem_req, mem_misaligned pulses 1 cycle, mem_stall stays 0.
- With DMEM_TIMEOUT_EN and TIMEOUT_CYCLES = 4, no ack -> req drops after 4 WAIT cycles, mem_fault pulse, Read_Data 0, FSM passes DONE then IDLE.
- Reset driven low during WAIT -> dmem_req and mem_stall go 0 immediately. A late ack after reset release is ignored, and the next load completes normally.
